store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Store-side counterpart of the load write-back path.
- Formats SB/SH/SW/SWL/SWR store data into a word-aligned write and generates little-endian byte enables.
- Flags misaligned stores as address errors.
- Queues accepted stores in a small FIFO write buffer that drains to the data bus over a req/ack handshake.
- Sits between the memory stage and the data-bus interface.
- Requests a pipeline stall when the buffer cannot accept a store, or when a load must wait for pending stores to drain.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- st_type  in  3  store op: 0 none, 1 SB, 2 SH, 3 SW, 4 SWL, 5 SWR; 6/7 treated as none.
- st_vaddr  in  32  store address.
- st_data  in  32  register (rt) value to store.
- ld_req  in  1  memory stage holds a load this cycle.
- flush  in  1  pipeline flush; current-cycle store is not accepted; queued entries are kept.
- stallreq  out  1  stall the pipeline this cycle.
- adel_st  out  1  store address error, combinational; no entry is pushed.
- bus_req  out  1  write request valid.
- bus_addr  out  32  {entry addr[31:2], 2'b00}.
- bus_wen  out  4  byte enables; bit i covers bus_wdata[8i+7:8i].
- bus_wdata  out  32  aligned write data.
- bus_ack  in  1  bus accepted the head entry this cycle.
- empty  out  1  buffer holds no entries.

Behaviour:
- Reset (resetn low, any time, including mid-drain):
  - head, tail and count go to 0.
  - bus_req=0, bus_wen=0, bus_addr=0, bus_wdata=0, empty=1, stallreq=0.
  - Queued entries are discarded.
- Formatting, combinational; a = st_vaddr[1:0]:
  - SB: wen = 1<<a; data = byte rt[7:0] replicated in all 4 lanes.
  - SH: a=0 gives wen 0011, data {rt[15:0],rt[15:0]}; a=2 gives wen 1100, same data; a=1 or a=3 raises adel_st.
  - SW: a=0 gives wen 1111, data rt; any other a raises adel_st.
  - SWL by a:
    - a=0: wen 0001, data {24'b0, rt[31:24]}
    - a=1: wen 0011, data {16'b0, rt[31:16]}
    - a=2: wen 0111, data {8'b0, rt[31:8]}
    - a=3: wen 1111, data rt
  - SWR by a:
    - a=0: wen 1111, data rt
    - a=1: wen 1110, data {rt[23:0], 8'b0}
    - a=2: wen 1100, data {rt[15:0], 16'b0}
    - a=3: wen 1000, data {rt[7:0], 24'b0}
  - adel_st is 0 whenever st_type is none.
- Push:
  - st_valid = st_type in 1..5.
  - push = st_valid & !adel_st & !flush & (count != DEPTH).
  - On push, entry {vaddr[31:2], wen, data} is written at tail; tail wraps modulo DEPTH.
- Drain:
  - bus_req = (count != 0); bus_* are driven from the head entry, registered storage read.
  - pop = bus_req & bus_ack; head wraps modulo DEPTH.
  - bus_addr, bus_wen and bus_wdata stay stable while bus_req=1 and bus_ack=0.
- Count:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, push is decided on the start-of-cycle count; a pop in the same cycle does not admit the push.
- stallreq = (st_valid & !adel_st & !flush & count==DEPTH) | (ld_req & count!=0).
  - Loads are conservatively ordered behind all pending stores.
  - The stalled store or load re-presents next cycle with the same inputs.
- empty = (count == 0).
- Latency: an entry pushed in cycle N drives bus_req at N+1 at the earliest, when the buffer was empty.
- Throughput: 1 store per cycle in, 1 write per acked cycle out.

Test Plan:
1. Reset, then SB at addr 0x1003 with rt=0x000000A5, bus_ack held 1.
   - Next cycle: bus_req=1, bus_addr=0x1000, bus_wen=1000, bus_wdata=0xA5A5A5A5.
   - Following cycle: empty=1.
2. SWL then SWR at 0x2001, rt=0x11223344.
   - SWL entry: wen 0011, data 0x00001122.
   - SWR entry: wen 1110, data 0x22334400.
   - Both drain in order.
3. SH at 0x3001 and SW at 0x3002.
   - adel_st=1 each cycle; count stays 0; bus_req stays 0.
4. Hold bus_ack=0 and issue 5 SW stores (DEPTH=4).
   - 4 accepted, then stallreq=1 with count=4 and bus outputs stable.
   - Assert bus_ack one cycle: that cycle stallreq is still 1.
   - Next cycle the 5th store pushes; FIFO order is preserved across wrap.
5. One store queued with bus_ack=0, then ld_req=1.
   - stallreq=1 until ack; stallreq=0 the cycle after the pop.
6. Three entries queued, resetn pulsed low mid-drain.
   - All outputs return to reset values immediately; no further bus_req.
   - flush with an SW present: no push and stallreq=0.

Source files
------------

// File: rtl/store_buffer.sv
// Store-side write buffer: formats SB/SH/SW/SWL/SWR into aligned byte-enabled
// writes, queues them in a small FIFO and drains them over a req/ack bus.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_vaddr,
  input  logic [31:0] st_data,
  input  logic        ld_req,
  input  logic        flush,
  output logic        stallreq,
  output logic        adel_st,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [29:0]   addr_mem_r [DEPTH];
  logic [3:0]    wen_mem_r  [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   count_r;

  logic [3:0]  fmt_wen_s;
  logic [31:0] fmt_data_s;
  logic        adel_s;
  logic        st_valid_s;
  logic        full_s;
  logic        nonempty_s;
  logic        push_s;
  logic        pop_s;

  // Store formatting: lane placement, byte enables and alignment check
  always_comb begin
    fmt_wen_s  = 4'b0000;
    fmt_data_s = 32'h0000_0000;
    adel_s     = 1'b0;
    st_valid_s = 1'b0;
    case (st_type)
      3'd1: begin
        st_valid_s = 1'b1;
        fmt_wen_s  = 4'b0001 << st_vaddr[1:0];
        fmt_data_s = {4{st_data[7:0]}};
      end
      3'd2: begin
        st_valid_s = 1'b1;
        fmt_data_s = {2{st_data[15:0]}};
        case (st_vaddr[1:0])
          2'd0:    fmt_wen_s = 4'b0011;
          2'd2:    fmt_wen_s = 4'b1100;
          default: adel_s    = 1'b1;
        endcase
      end
      3'd3: begin
        st_valid_s = 1'b1;
        fmt_data_s = st_data;
        case (st_vaddr[1:0])
          2'd0:    fmt_wen_s = 4'b1111;
          default: adel_s    = 1'b1;
        endcase
      end
      3'd4: begin
        st_valid_s = 1'b1;
        case (st_vaddr[1:0])
          2'd0:    begin fmt_wen_s = 4'b0001; fmt_data_s = {24'h000000, st_data[31:24]}; end
          2'd1:    begin fmt_wen_s = 4'b0011; fmt_data_s = {16'h0000, st_data[31:16]}; end
          2'd2:    begin fmt_wen_s = 4'b0111; fmt_data_s = {8'h00, st_data[31:8]}; end
          default: begin fmt_wen_s = 4'b1111; fmt_data_s = st_data; end
        endcase
      end
      3'd5: begin
        st_valid_s = 1'b1;
        case (st_vaddr[1:0])
          2'd0:    begin fmt_wen_s = 4'b1111; fmt_data_s = st_data; end
          2'd1:    begin fmt_wen_s = 4'b1110; fmt_data_s = {st_data[23:0], 8'h00}; end
          2'd2:    begin fmt_wen_s = 4'b1100; fmt_data_s = {st_data[15:0], 16'h0000}; end
          default: begin fmt_wen_s = 4'b1000; fmt_data_s = {st_data[7:0], 24'h000000}; end
        endcase
      end
      default: begin
        st_valid_s = 1'b0;
      end
    endcase
  end

  assign full_s     = (count_r == FULL_CNT);
  assign nonempty_s = (count_r != '0);
  // Full is judged on the start-of-cycle count, so a same-cycle pop never admits a push
  assign push_s     = st_valid_s & ~adel_s & ~flush & ~full_s;
  assign pop_s      = nonempty_s & bus_ack;

  assign adel_st  = adel_s;
  assign stallreq = (st_valid_s & ~adel_s & ~flush & full_s) | (ld_req & nonempty_s);
  assign empty    = ~nonempty_s;
  assign bus_req  = nonempty_s;

  // Head entry is read from registered storage; gated to zero when nothing is queued
  always_comb begin
    bus_addr  = 32'h0000_0000;
    bus_wen   = 4'b0000;
    bus_wdata = 32'h0000_0000;
    if (nonempty_s) begin
      bus_addr  = {addr_mem_r[head_r], 2'b00};
      bus_wen   = wen_mem_r[head_r];
      bus_wdata = data_mem_r[head_r];
    end else begin
      bus_addr  = 32'h0000_0000;
    end
  end

  // Entry storage written at the tail on an accepted store
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= st_vaddr[31:2];
      wen_mem_r[tail_r]  <= fmt_wen_s;
      data_mem_r[tail_r] <= fmt_data_s;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) tail_r <= tail_r + AW'(1);
      if (pop_s)  head_r <= head_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  st_type;
  logic [31:0] st_vaddr, st_data;
  logic        ld_req, flush, bus_ack;
  logic        stallreq, adel_st, bus_req, empty;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wen;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .st_type(st_type), .st_vaddr(st_vaddr),
    .st_data(st_data), .ld_req(ld_req), .flush(flush), .stallreq(stallreq),
    .adel_st(adel_st), .bus_req(bus_req), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .empty(empty)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        pend;
  int          n_vec, n_err;
  logic        e_adel, e_stall, e_req, e_empty, e_push;
  logic [31:0] e_addr, e_data;
  logic [3:0]  e_wen;

  // Byte-lane model: SWL writes the top a+1 bytes of rt into the low lanes,
  // SWR writes the low 4-a bytes of rt into the high lanes.
  function automatic void fmt(input logic [2:0] t, input logic [31:0] va, input logic [31:0] rt,
                              output logic [3:0] wen, output logic [31:0] data,
                              output logic adel, output logic valid);
    int a;
    a = int'(va[1:0]);
    wen = 4'b0000; data = 32'h0; adel = 1'b0; valid = 1'b1;
    case (t)
      3'd1: begin wen = 4'(1 << a); data = {4{rt[7:0]}}; end
      3'd2: begin adel = (a % 2) != 0; wen = 4'(3 << a); data = {2{rt[15:0]}}; end
      3'd3: begin adel = (a != 0); wen = 4'hF; data = rt; end
      3'd4: begin wen = 4'((1 << (a + 1)) - 1); data = rt >> (8 * (3 - a)); end
      3'd5: begin wen = 4'(15 << a); data = rt << (8 * a); end
      default: valid = 1'b0;
    endcase
  endfunction

  function automatic void predict();
    logic [3:0] w; logic [31:0] d; logic ad, v;
    fmt(st_type, st_vaddr, st_data, w, d, ad, v);
    e_adel  = ad;
    e_push  = v && !ad && !flush && (q.size() < DEPTH);
    e_stall = (v && !ad && !flush && (q.size() == DEPTH)) || (ld_req && (q.size() != 0));
    e_req   = (q.size() != 0);
    e_empty = !e_req;
    pend    = '{addr: {st_vaddr[31:2], 2'b00}, wen: w, data: d};
    if (e_req) begin
      e_addr = q[0].addr; e_wen = q[0].wen; e_data = q[0].data;
    end else begin
      e_addr = 32'h0; e_wen = 4'h0; e_data = 32'h0;
    end
  endfunction

  task automatic drive(input logic [2:0] t, input logic [31:0] va, input logic [31:0] rt,
                       input logic ld, input logic fl, input logic ack);
    @(negedge clk);
    st_type = t; st_vaddr = va; st_data = rt; ld_req = ld; flush = fl; bus_ack = ack;
    #1;
    predict();
  endtask

  task automatic tick();
    logic pop, psh;
    ent_t p;
    pop = e_req && bus_ack;
    psh = e_push;
    p   = pend;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (psh) q.push_back(p);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++;
    if ({bus_req, bus_wen, bus_addr, bus_wdata, empty, stallreq} !== {1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: got req=%b wen=%h addr=%h data=%h empty=%b stall=%b want 0/0/0/0/1/0",
               bus_req, bus_wen, bus_addr, bus_wdata, empty, stallreq);
      n_err++;
    end
    resetn = 1'b1;
  endtask

  task automatic test_sb();
    drive(3'd1, 32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({adel_st, stallreq, bus_req} !== 3'b000) begin
      $display("FAIL sb_accept: got adel/stall/req=%b want 000", {adel_st, stallreq, bus_req}); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus_req, bus_addr, bus_wen, bus_wdata} !== {1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
      $display("FAIL sb_bus: got req=%b addr=%h wen=%b data=%h want 1 00001000 1000 a5a5a5a5",
               bus_req, bus_addr, bus_wen, bus_wdata); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (empty !== 1'b1) begin
      $display("FAIL sb_empty: got %b want 1", empty); n_err++;
    end
    tick();
  endtask

  task automatic test_swl_swr();
    drive(3'd4, 32'h0000_2001, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3'd5, 32'h0000_2001, 32'h1122_3344, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({bus_addr, bus_wen, bus_wdata} !== {32'h0000_2000, 4'b0011, 32'h0000_1122}) begin
      $display("FAIL swl_entry: got addr=%h wen=%b data=%h want 00002000 0011 00001122",
               bus_addr, bus_wen, bus_wdata); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus_wen, bus_wdata} !== {4'b0011, 32'h0000_1122}) begin
      $display("FAIL swl_order: got wen=%b data=%h want 0011 00001122", bus_wen, bus_wdata); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus_req, bus_addr, bus_wen, bus_wdata} !== {1'b1, 32'h0000_2000, 4'b1110, 32'h2233_4400}) begin
      $display("FAIL swr_entry: got req=%b addr=%h wen=%b data=%h want 1 00002000 1110 22334400",
               bus_req, bus_addr, bus_wen, bus_wdata); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (empty !== 1'b1) begin
      $display("FAIL swlswr_drained: got empty=%b want 1", empty); n_err++;
    end
    tick();
  endtask

  task automatic test_adel();
    logic [2:0]  ty [2];
    logic [31:0] ad [2];
    ty[0] = 3'd2; ad[0] = 32'h0000_3001;
    ty[1] = 3'd3; ad[1] = 32'h0000_3002;
    for (int i = 0; i < 2; i++) begin
      drive(ty[i], ad[i], $urandom, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({adel_st, stallreq, bus_req} !== 3'b100) begin
        $display("FAIL adel_%0d: got adel/stall/req=%b want 100", i, {adel_st, stallreq, bus_req}); n_err++;
      end
      tick();
    end
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({bus_req, empty} !== 2'b01) begin
      $display("FAIL adel_nopush: got req/empty=%b want 01", {bus_req, empty}); n_err++;
    end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [31:0] wd [5];
    for (int i = 0; i < 5; i++) wd[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      drive(3'd3, 32'(32'h4000 + 4 * i), wd[i], 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (stallreq !== (i == 4)) begin
        $display("FAIL fill_stall_%0d: got %b want %b", i, stallreq, (i == 4)); n_err++;
      end
      if (i > 0) begin
        n_vec++;
        if ({bus_addr, bus_wdata} !== {32'h0000_4000, wd[0]}) begin
          $display("FAIL fill_stable_%0d: got addr=%h data=%h want 00004000 %h", i, bus_addr, bus_wdata, wd[0]);
          n_err++;
        end
      end
      tick();
    end
    drive(3'd3, 32'h0000_4010, wd[4], 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (stallreq !== 1'b1) begin
      $display("FAIL full_ack_stall: got %b want 1", stallreq); n_err++;
    end
    tick();
    drive(3'd3, 32'h0000_4010, wd[4], 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({stallreq, bus_addr, bus_wdata} !== {1'b0, 32'h0000_4004, wd[1]}) begin
      $display("FAIL full_repush: got stall=%b addr=%h data=%h want 0 00004004 %h", stallreq, bus_addr, bus_wdata, wd[1]);
      n_err++;
    end
    tick();
    for (int k = 2; k < 5; k++) begin
      drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_vec++;
      if ({bus_req, bus_addr, bus_wen, bus_wdata} !== {1'b1, 32'(32'h4000 + 4 * k), 4'hF, wd[k]}) begin
        $display("FAIL wrap_order_%0d: got req=%b addr=%h wen=%b data=%h want 1 %h 1111 %h",
                 k, bus_req, bus_addr, bus_wen, bus_wdata, 32'(32'h4000 + 4 * k), wd[k]); n_err++;
      end
      tick();
    end
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (empty !== 1'b1) begin
      $display("FAIL wrap_drained: got empty=%b want 1", empty); n_err++;
    end
    tick();
  endtask

  task automatic test_load();
    logic [3:0] ack_seq;
    logic [3:0] stall_exp;
    ack_seq   = 4'b0100;
    stall_exp = 4'b0111;
    drive(3'd3, 32'h0000_5000, $urandom, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b0, ack_seq[i]);
      n_vec++;
      if (stallreq !== stall_exp[i]) begin
        $display("FAIL load_stall_%0d: got %b want %b", i, stallreq, stall_exp[i]); n_err++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(3'd3, 32'(32'h6000 + 4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus_req !== 1'b1) begin
      $display("FAIL mid_req: got %b want 1", bus_req); n_err++;
    end
    tick();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    q.delete();
    n_vec++;
    if ({bus_req, bus_wen, bus_addr, bus_wdata, empty, stallreq} !== {1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
      $display("FAIL mid_reset: got req=%b wen=%h addr=%h data=%h empty=%b stall=%b want 0/0/0/0/1/0",
               bus_req, bus_wen, bus_addr, bus_wdata, empty, stallreq); n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus_req !== 1'b0) begin
      $display("FAIL mid_reset_hold: got req=%b want 0", bus_req); n_err++;
    end
    @(negedge clk);
    resetn = 1'b1;
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus_req !== 1'b0) begin
      $display("FAIL post_reset_req: got %b want 0", bus_req); n_err++;
    end
    tick();
    drive(3'd3, 32'h0000_6100, $urandom, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ({stallreq, adel_st} !== 2'b00) begin
      $display("FAIL flush_stall: got stall/adel=%b want 00", {stallreq, adel_st}); n_err++;
    end
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus_req, empty} !== 2'b01) begin
      $display("FAIL flush_nopush: got req/empty=%b want 01", {bus_req, empty}); n_err++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      n_vec++;
      if ({stallreq, adel_st, bus_req, empty} !== {e_stall, e_adel, e_req, e_empty}) begin
        $display("FAIL rand_ctrl_%0d: got stall/adel/req/empty=%b want %b", c,
                 {stallreq, adel_st, bus_req, empty}, {e_stall, e_adel, e_req, e_empty}); n_err++;
      end
      n_vec++;
      if ({bus_addr, bus_wen, bus_wdata} !== {e_addr, e_wen, e_data}) begin
        $display("FAIL rand_bus_%0d: got addr=%h wen=%b data=%h want addr=%h wen=%b data=%h", c,
                 bus_addr, bus_wen, bus_wdata, e_addr, e_wen, e_data); n_err++;
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    resetn = 1'b0;
    st_type = 3'd0; st_vaddr = 32'h0; st_data = 32'h0;
    ld_req = 1'b0; flush = 1'b0; bus_ack = 1'b0;
    e_push = 1'b0; e_req = 1'b0;
    test_reset();
    test_sb();
    test_swl_swr();
    test_adel();
    test_full_wrap();
    test_load();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
